shift_operand_sequencer: RTL and testbench
==========================================

// Module: shift_operand_sequencer
// PURPOSE
// - Multi-cycle controller for the operand-2 shifter of the data-processing path.
// - Takes the 8-bit shift field, the Rm value and the C flag.
// - For register-specified shifts, fetches Rs through the shared register-file read port (req/gnt).
// - Runs an iterative shift of up to STEP bits per cycle.
// - Returns the shifted operand and shifter carry-out over a valid/ready handshake.
// PARAMETERS
// - STEP  8  bits shifted per CALC cycle. Power of 2, 1..32.
// PORTS
// - clk          in   1   clock. All state is on the rising edge.
// - reset        in   1   asynchronous, active-high reset.
// - in_valid     in   1   request valid.
// - in_ready     out  1   block can accept a request. High only in IDLE, low while reset is asserted.
// - shift_field  in   8   [0]=register-specified, [2:1]=type (00 LSL, 01 LSR, 10 ASR, 11 ROR),
//                         [7:3]=imm5 (immediate form), [7:4]=Rs index (register form).
// - rm_value     in   32  operand to shift. Sampled on accept.
// - carry_in     in   1   current C flag. Sampled on accept.
// - rf_req       out  1   request for the shared register-file read port.
// - rf_addr      out  4   Rs index. Stable while rf_req is high, 0 otherwise.
// - rf_gnt       in   1   port granted this cycle. rf_data is valid in the same cycle.
// - rf_data      in   32  Rs value.
// - out_valid    out  1   result and carry_out are valid.
// - out_ready    in   1   consumer accepts the result.
// - result       out  32  shifted operand.
// - carry_out    out  1   shifter carry-out.
// BEHAVIOUR
// - States: IDLE, RS_REQ, CALC, DONE. Reset: IDLE, out_valid=0, rf_req=0, result=0, carry_out=0.
//   Reset asserted in any state aborts at once; no pending request survives.
// - IDLE: accept on in_valid&&in_ready. Latch rm_value into result, latch carry_in, type.
//   Register form -> RS_REQ; immediate form -> CALC.
// - RS_REQ: rf_req=1, rf_addr=Rs. Stay until rf_gnt. On the grant cycle take amt=rf_data[7:0] -> CALC.
// - Effective amount and remaining counter rem (6 bits), set on entry to CALC:
//   - imm LSL #0: rem=0, carry=C.
//   - imm LSR/ASR #0: amount is 32.
//   - imm ROR #0: RRX.
//   - reg, amt==0: rem=0, result=Rm, carry=C (all types).
//   - LSL/LSR amt>32: rem=33.
//   - ASR amt>32: rem=32.
//   - ROR amt!=0 and amt[4:0]==0: result=Rm, carry=Rm[31], rem=0. Otherwise ROR rem=amt[4:0].
// - CALC: each cycle shift by k=min(STEP,rem); rem-=k.
//   - carry_out = last bit shifted out. LSL: bit 32-k. LSR/ASR/ROR: bit k-1.
//   - LSL/LSR shifting beyond 32 bits fills with 0 and carry becomes 0.
//   - ASR fills with sign.
//   - RRX is one cycle: result={C,Rm[31:1]}, carry=Rm[0].
//   - Go to DONE when rem reaches 0. rem==0 on entry still costs exactly one CALC cycle (no change).
// - Latency:
//   - Immediate form: accept at cycle T -> out_valid at T+1+max(1,ceil(rem/STEP)).
//   - Register form: grant at cycle G -> out_valid at G+1+max(1,ceil(rem/STEP)).
// - DONE: out_valid=1. result and carry_out are held stable until out_ready. Then go to IDLE with out_valid=0.
//   No new accept in the same cycle; in_ready rises the next cycle.
// - Only one request is in flight. in_valid is ignored outside IDLE.
// TESTING
// - imm LSL #4, Rm=0x1000_000F, C=0 -> result 0x0000_00F0, carry 1, out_valid at T+2 (STEP=8).
// - imm LSR #0, Rm=0x8000_0001 -> result 0, carry 1, four CALC cycles, out_valid at T+5.
// - imm ROR #0 (RRX), Rm=0x0000_0003, C=1 -> result 0x8000_0001, carry 1, out_valid at T+2.
// - reg ASR, Rs=3, rf_gnt withheld 3 cycles, rf_data=0x0000_0124, Rm=0x8000_0000
//   -> rf_req=1 and rf_addr=3 stable until grant; result 0xFFFF_FFFF, carry 1.
// - reg LSL, rf_data=0xFFFF_FF00 (amt 0), Rm=0x1234_5678, C=1 -> result 0x1234_5678, carry 1.
// - out_ready low 5 cycles in DONE -> result, carry_out and out_valid held, in_ready=0.
//   reset pulse during CALC -> out_valid=0 and rf_req=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/shift_operand_sequencer_if.sv
// Handshake and register-file bundle for the operand-2 shift sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
interface shift_operand_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  shift_field;
  logic [31:0] rm_value;
  logic        carry_in;
  logic        rf_req;
  logic [3:0]  rf_addr;
  logic        rf_gnt;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;

  modport master (
    output in_valid, shift_field, rm_value, carry_in, rf_gnt, rf_data, out_ready,
    input  in_ready, rf_req, rf_addr, out_valid, result, carry_out
  );

  modport slave (
    input  in_valid, shift_field, rm_value, carry_in, rf_gnt, rf_data, out_ready,
    output in_ready, rf_req, rf_addr, out_valid, result, carry_out
  );
endinterface

// File: rtl/shift_operand_sequencer.sv
// Multi-cycle operand-2 shifter: optional Rs fetch over a shared register-file port,
// then an iterative shift of up to STEP bits per cycle, result over valid/ready.
module shift_operand_sequencer #(
  parameter int unsigned STEP = 8
) (
  input logic                      clk,
  input logic                      reset,
  shift_operand_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRsReq, StCalc, StDone} state_e;

  localparam logic [1:0] TyLsl = 2'b00;
  localparam logic [1:0] TyLsr = 2'b01;
  localparam logic [1:0] TyAsr = 2'b10;
  localparam logic [1:0] TyRor = 2'b11;
  localparam logic [5:0] StepW = 6'(STEP);

  typedef struct packed {
    logic [5:0] rem;
    logic       rrx;
    logic       carry;
  } setup_t;

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  rs_q, rs_d;
  logic [5:0]  rem_q, rem_d;
  logic        rrx_q, rrx_d;

  logic [5:0]  k;
  logic [63:0] wide;
  logic [31:0] shifted;
  logic        shift_carry;
  setup_t      setup;
  logic        unused_rf_data;

  assign unused_rf_data = ^bus.rf_data[31:8];

  // Translate the raw amount into a remaining-bit count plus the special-case carries.
  function automatic setup_t calc_setup(input logic reg_form, input logic [1:0] typ,
                                        input logic [7:0] amt, input logic rm_msb,
                                        input logic c);
    setup_t s;
    s.rem   = 6'd0;
    s.rrx   = 1'b0;
    s.carry = c;
    if (!reg_form) begin
      if (amt[4:0] == 5'd0) begin
        unique case (typ)
          TyLsl:        s.rem = 6'd0;
          TyLsr, TyAsr: s.rem = 6'd32;
          TyRor:        s.rrx = 1'b1;
        endcase
      end else begin
        s.rem = {1'b0, amt[4:0]};
      end
    end else if (amt != 8'd0) begin
      unique case (typ)
        TyLsl, TyLsr: s.rem = (amt > 8'd32) ? 6'd33 : amt[5:0];
        TyAsr:        s.rem = (amt > 8'd32) ? 6'd32 : amt[5:0];
        TyRor: begin
          if (amt[4:0] == 5'd0) s.carry = rm_msb;
          else                  s.rem   = {1'b0, amt[4:0]};
        end
      endcase
    end
    return s;
  endfunction

  assign k = (rem_q > StepW) ? StepW : rem_q;

  // One step of the shift; the carry is the last bit to fall off the end.
  always_comb begin
    wide        = 64'd0;
    shifted     = result_q;
    shift_carry = carry_q;
    unique case (type_q)
      TyLsl: begin
        wide        = {32'd0, result_q} << k;
        shifted     = wide[31:0];
        shift_carry = wide[32];
      end
      TyLsr: begin
        wide        = {result_q, 32'd0} >> k;
        shifted     = wide[63:32];
        shift_carry = wide[31];
      end
      TyAsr: begin
        wide        = $signed({result_q, 32'd0}) >>> k;
        shifted     = wide[63:32];
        shift_carry = wide[31];
      end
      TyRor: begin
        wide        = {result_q, result_q} >> k;
        shifted     = wide[31:0];
        shift_carry = wide[31];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    type_d   = type_q;
    rs_d     = rs_q;
    rem_d    = rem_q;
    rrx_d    = rrx_q;
    setup    = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          result_d = bus.rm_value;
          carry_d  = bus.carry_in;
          type_d   = bus.shift_field[2:1];
          rs_d     = bus.shift_field[7:4];
          rrx_d    = 1'b0;
          rem_d    = 6'd0;
          if (bus.shift_field[0]) begin
            state_d = StRsReq;
          end else begin
            setup   = calc_setup(1'b0, bus.shift_field[2:1], {3'd0, bus.shift_field[7:3]},
                                 bus.rm_value[31], bus.carry_in);
            rem_d   = setup.rem;
            rrx_d   = setup.rrx;
            carry_d = setup.carry;
            state_d = StCalc;
          end
        end
      end
      StRsReq: begin
        if (bus.rf_gnt) begin
          setup   = calc_setup(1'b1, type_q, bus.rf_data[7:0], result_q[31], carry_q);
          rem_d   = setup.rem;
          rrx_d   = setup.rrx;
          carry_d = setup.carry;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (rrx_q) begin
          result_d = {carry_q, result_q[31:1]};
          carry_d  = result_q[0];
          rrx_d    = 1'b0;
        end else if (rem_q != 6'd0) begin
          result_d = shifted;
          carry_d  = shift_carry;
          rem_d    = rem_q - k;
        end
        // A zero count still spends this one cycle here.
        if (rem_q == k) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= 32'd0;
      carry_q  <= 1'b0;
      type_q   <= 2'd0;
      rs_q     <= 4'd0;
      rem_q    <= 6'd0;
      rrx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      type_q   <= type_d;
      rs_q     <= rs_d;
      rem_q    <= rem_d;
      rrx_q    <= rrx_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !reset;
  assign bus.rf_req    = (state_q == StRsReq);
  assign bus.rf_addr   = (state_q == StRsReq) ? rs_q : 4'd0;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Scoreboard bench for shift_operand_sequencer: expected results come from an
// architectural shifter model and are checked when out_valid appears.
module tb_shift_operand_sequencer;
  localparam int unsigned STEP = 8;

  logic clk = 1'b0;
  logic reset;

  shift_operand_sequencer_if bus ();

  shift_operand_sequencer #(.STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic        carry;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Whole-shift reference: {carry, result}.
  function automatic logic [32:0] model(input logic [7:0] f, input logic [31:0] rm,
                                        input logic c, input logic [31:0] rs);
    int n;
    int m;
    logic [1:0] t;
    t = f[2:1];
    if (!f[0]) begin
      n = int'(f[7:3]);
      if (n == 0) begin
        case (t)
          2'd0:    return {c, rm};
          2'd1:    return {rm[31], 32'h0};
          2'd2:    return {rm[31], {32{rm[31]}}};
          default: return {rm[0], c, rm[31:1]};
        endcase
      end
    end else begin
      n = int'(rs[7:0]);
      if (n == 0) return {c, rm};
    end
    case (t)
      2'd0: begin
        if (n < 32) return {rm[32-n], rm << n};
        if (n == 32) return {rm[0], 32'h0};
        return 33'h0;
      end
      2'd1: begin
        if (n < 32) return {rm[n-1], rm >> n};
        if (n == 32) return {rm[31], 32'h0};
        return 33'h0;
      end
      2'd2: begin
        if (n < 32) return {rm[n-1], 32'($signed(rm) >>> n)};
        return {rm[31], {32{rm[31]}}};
      end
      default: begin
        m = n % 32;
        if (m == 0) return {rm[31], rm};
        return {rm[m-1], (rm >> m) | (rm << (32 - m))};
      end
    endcase
  endfunction

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.shift_field = 8'd0;
    bus.rm_value    = 32'd0;
    bus.carry_in    = 1'b0;
    bus.rf_gnt      = 1'b0;
    bus.rf_data     = 32'd0;
    bus.out_ready   = 1'b0;
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] f, input logic [31:0] rm, input logic c,
                      input logic [31:0] rs, input int lat, input string name);
    exp_t e;
    logic [32:0] m;
    int n;
    n = 0;
    bus.in_valid    = 1'b1;
    bus.shift_field = f;
    bus.rm_value    = rm;
    bus.carry_in    = c;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: in_ready=%b required 1", name, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    m = model(f, rm, c, rs);
    e.result = m[31:0];
    e.carry  = m[32];
    e.lat    = lat;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic grant(input int wait_cyc, input logic [3:0] addr, input logic [31:0] data,
                       input string name);
    for (int i = 0; i <= wait_cyc; i++) begin
      n_vec++;
      if (bus.rf_req !== 1'b1 || bus.rf_addr !== addr) begin
        n_err++;
        $display("FAIL %s rf_req/rf_addr cycle %0d: got %b/%0d required 1/%0d",
                 name, i, bus.rf_req, bus.rf_addr, addr);
      end
      if (i == wait_cyc) begin
        bus.rf_gnt  = 1'b1;
        bus.rf_data = data;
      end
      @(posedge clk); #1;
    end
    bus.rf_gnt  = 1'b0;
    bus.rf_data = $urandom;
    n_vec++;
    if (bus.rf_req !== 1'b0 || bus.rf_addr !== 4'd0) begin
      n_err++;
      $display("FAIL %s rf_req after grant: got %b/%0d required 0/0",
               name, bus.rf_req, bus.rf_addr);
    end
  endtask

  // Waits for out_valid, counting edges from the call point, then holds off out_ready.
  task automatic recv(input int hold);
    exp_t e;
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: empty with out_valid=%b required an entry", bus.out_valid);
      return;
    end
    e = sb.pop_front();
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: out_valid=%b required 1", e.name, bus.out_valid);
      return;
    end
    if (e.lat >= 0) begin
      n_vec++;
      if (n != e.lat) begin
        n_err++;
        $display("FAIL %s latency: got %0d required %0d", e.name, n, e.lat);
      end
    end
    n_vec++;
    if (bus.result !== e.result || bus.carry_out !== e.carry) begin
      n_err++;
      $display("FAIL %s result: got %h/%b required %h/%b",
               e.name, bus.result, bus.carry_out, e.result, e.carry);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.result !== e.result || bus.carry_out !== e.carry ||
          bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold %0d: got v=%b %h/%b rdy=%b required 1 %h/%b 0", e.name, i,
                 bus.out_valid, bus.result, bus.carry_out, bus.in_ready, e.result, e.carry);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s release: got v=%b rdy=%b required 0 1",
               e.name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.rf_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset ctrl: rdy/v/req=%b%b%b required 000",
               bus.in_ready, bus.out_valid, bus.rf_req);
    end
    n_vec++;
    if (bus.result !== 32'd0 || bus.carry_out !== 1'b0 || bus.rf_addr !== 4'd0) begin
      n_err++;
      $display("FAIL reset data: got %h/%b/%0d required 0/0/0",
               bus.result, bus.carry_out, bus.rf_addr);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset release: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_immediate();
    send(8'h20, 32'h1000_000F, 1'b0, 32'd0, 1, "imm_lsl4");
    recv(0);
    send(8'h02, 32'h8000_0001, 1'b0, 32'd0, 4, "imm_lsr0");
    recv(0);
    send(8'h06, 32'h0000_0003, 1'b1, 32'd0, 1, "imm_rrx");
    recv(0);
    send(8'h04, 32'h8000_0000, 1'b0, 32'd0, 4, "imm_asr0");
    recv(0);
    send({5'd31, 2'b00, 1'b0}, 32'hFFFF_FFFF, 1'b0, 32'd0, 4, "imm_lsl31");
    recv(0);
    send({5'd9, 2'b01, 1'b0}, 32'hDEAD_BEEF, 1'b0, 32'd0, 2, "imm_lsr9");
    recv(0);
  endtask

  task automatic test_register();
    send(8'h35, 32'h8000_0000, 1'b0, 32'h0000_0124, 4, "reg_asr_wait");
    grant(3, 4'd3, 32'h0000_0124, "reg_asr_wait");
    recv(0);
    send(8'h51, 32'h1234_5678, 1'b1, 32'hFFFF_FF00, 1, "reg_lsl0");
    grant(0, 4'd5, 32'hFFFF_FF00, "reg_lsl0");
    recv(0);
    send(8'hA1, 32'h8765_4321, 1'b0, 32'h0000_0020, 4, "reg_lsl32");
    grant(1, 4'hA, 32'h0000_0020, "reg_lsl32");
    recv(0);
    send(8'h73, 32'hFFFF_FFFF, 1'b1, 32'h0000_0021, 5, "reg_lsr33");
    grant(0, 4'h7, 32'h0000_0021, "reg_lsr33");
    recv(0);
    send(8'hF7, 32'h8000_0001, 1'b0, 32'h0000_0040, 1, "reg_ror64");
    grant(2, 4'hF, 32'h0000_0040, "reg_ror64");
    recv(0);
    send(8'h27, 32'h0000_00F1, 1'b0, 32'h0000_0004, 1, "reg_ror4");
    grant(0, 4'h2, 32'h0000_0004, "reg_ror4");
    recv(0);
  endtask

  task automatic test_backpressure();
    send(8'h20, 32'h1000_000F, 1'b1, 32'd0, 1, "backpressure");
    bus.in_valid    = 1'b1;
    bus.shift_field = 8'h02;
    recv(5);
  endtask

  task automatic test_reset_mid();
    send(8'h02, 32'hF0F0_F0F0, 1'b1, 32'd0, 4, "rst_calc");
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.rf_req !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.result !== 32'd0) begin
      n_err++;
      $display("FAIL rst_calc abort: v/req/rdy=%b%b%b res=%h required 000 0",
               bus.out_valid, bus.rf_req, bus.in_ready, bus.result);
    end
    void'(sb.pop_back());
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_calc release: rdy=%b v=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    send(8'h91, 32'h0000_0001, 1'b0, 32'd1, -1, "rst_rsreq");
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.rf_req !== 1'b0 || bus.rf_addr !== 4'd0) begin
      n_err++;
      $display("FAIL rst_rsreq abort: req=%b addr=%0d required 0 0", bus.rf_req, bus.rf_addr);
    end
    void'(sb.pop_back());
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.rf_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rsreq release: rdy=%b req=%b required 1 0", bus.in_ready, bus.rf_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] picks [10];
    logic [7:0]  f;
    logic [31:0] rm;
    logic [31:0] rs;
    picks = '{32'd0, 32'd1, 32'd7, 32'd8, 32'd31, 32'd32, 32'd33, 32'd64, 32'd255, 32'h124};
    for (int i = 0; i < 24; i++) begin
      f  = 8'($urandom);
      rm = $urandom;
      rs = $urandom;
      rs[7:0] = picks[$urandom_range(0, 9)][7:0];
      send(f, rm, 1'($urandom), rs, -1, "b2b_random");
      if (f[0]) grant(int'($urandom_range(0, 3)), f[7:4], rs, "b2b_random");
      recv(0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_immediate();
    test_register();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
